// File: rtl/seg_top.sv
// Two-digit BCD event counter with a time-multiplexed 7-segment driver; count latency 1 clk, no backpressure.
// Define SEG_TOP_LEADING_BLANK_EN to blank the tens digit while it is zero.
module seg_top #(
    parameter int REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       count2,
    input  logic       count_ACK2,
    output logic [6:0] seg_out,
    output logic       digit_select
);

    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

    logic [3:0]       ones_q, ones_d;
    logic [3:0]       tens_q, tens_d;
    logic [REF_W-1:0] refresh_q, refresh_d;
    logic             digit_sel_q, digit_sel_d;
    logic             ack_prev_q, ack_prev_d;
    logic             inc;
    logic [3:0]       digit_val;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h7E;
            4'd1:    s = 7'h30;
            4'd2:    s = 7'h6D;
            4'd3:    s = 7'h79;
            4'd4:    s = 7'h33;
            4'd5:    s = 7'h5B;
            4'd6:    s = 7'h5F;
            4'd7:    s = 7'h70;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h7B;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_comb begin
        inc         = count_ACK2 & ~ack_prev_q & count2;
        ones_d      = ones_q;
        tens_d      = tens_q;
        ack_prev_d  = count_ACK2;
        refresh_d   = refresh_q + REF_W'(1);
        digit_sel_d = digit_sel_q;

        if (inc) begin
            if (ones_q < 4'd9) begin
                ones_d = ones_q + 4'd1;
            end else begin
                ones_d = 4'd0;
                tens_d = (tens_q < 4'd9) ? tens_q + 4'd1 : 4'd0;
            end
        end

        // Slot boundary: restart the divider and swap the displayed digit.
        if (refresh_q == REF_LAST) begin
            refresh_d   = '0;
            digit_sel_d = ~digit_sel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            ones_q      <= 4'd0;
            tens_q      <= 4'd0;
            refresh_q   <= '0;
            digit_sel_q <= 1'b0;
            ack_prev_q  <= 1'b0;
        end else begin
            ones_q      <= ones_d;
            tens_q      <= tens_d;
            refresh_q   <= refresh_d;
            digit_sel_q <= digit_sel_d;
            ack_prev_q  <= ack_prev_d;
        end
    end

    always_comb begin
        digit_val = digit_sel_q ? tens_q : ones_q;
        seg_out   = seg_decode(digit_val);
`ifdef SEG_TOP_LEADING_BLANK_EN
        if (digit_sel_q && (tens_q == 4'd0)) begin
            seg_out = 7'h00;
        end
`else
`endif
    end

    assign digit_select = digit_sel_q;

endmodule

// File: tb/tb_seg_top.sv
// Directed bench for seg_top with a per-cycle expected-output queue.
module tb_seg_top;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       count2 = 1'b0;
    logic       count_ACK2 = 1'b0;
    logic [6:0] seg_out;
    logic       digit_select;

    seg_top #(.REFRESH_DIV(DIV)) dut (
        .clk          (clk),
        .RESET        (RESET),
        .count2       (count2),
        .count_ACK2   (count_ACK2),
        .seg_out      (seg_out),
        .digit_select (digit_select)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic       ds;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [6:0] enc [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                             7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
`ifdef SEG_TOP_LEADING_BLANK_EN
    localparam logic [6:0] TENS_ZERO = 7'h00;
`else
    localparam logic [6:0] TENS_ZERO = 7'h7E;
`endif

    // Reference state, advanced once per clock by step().
    int   m_ones = 0, m_tens = 0, m_ref = 0;
    logic m_ds = 1'b0, m_prev = 1'b0;

    function automatic logic [6:0] model_seg();
        if (m_ds) return (m_tens == 0) ? TENS_ZERO : enc[m_tens];
        return enc[m_ones];
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic c2, input logic ack, input logic rst);
        exp_t e, got;
        RESET      = rst;
        count2     = c2;
        count_ACK2 = ack;
        if (rst) begin
            m_ones = 0; m_tens = 0; m_ref = 0; m_ds = 1'b0; m_prev = 1'b0;
        end else begin
            if (ack && !m_prev && c2) begin
                if (m_ones < 9) m_ones++;
                else begin
                    m_ones = 0;
                    m_tens = (m_tens < 9) ? m_tens + 1 : 0;
                end
            end
            m_prev = ack;
            if (m_ref == DIV - 1) begin
                m_ref = 0;
                m_ds  = ~m_ds;
            end else begin
                m_ref++;
            end
        end
        e.seg = model_seg();
        e.ds  = m_ds;
        q.push_back(e);
        @(posedge clk);
        #1;
        got = q.pop_front();
        chk("seg_out", seg_out, got.seg);
        chk("digit_select", {6'b0, digit_select}, {6'b0, got.ds});
    endtask

    task automatic pulse(input logic c2, input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(c2, 1'b1, 1'b0);
        for (int i = 0; i < lo; i++) step(c2, 1'b0, 1'b0);
    endtask

    // Idle until the requested slot is showing; bounded to one full refresh period.
    task automatic to_slot(input logic want);
        for (int i = 0; i < 2 * DIV + 1 && digit_select !== want; i++) step(1'b1, 1'b0, 1'b0);
        chk("slot_reached", {6'b0, digit_select}, {6'b0, want});
    endtask

    initial begin
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b1);
        chk("reset_seg", seg_out, 7'h7E);
        chk("reset_ds", {6'b0, digit_select}, 7'h00);

        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        to_slot(1'b1);
        chk("idle_tens", seg_out, TENS_ZERO);

        for (int i = 0; i < 10; i++) pulse(1'b1, 4, 4);
        to_slot(1'b0);
        chk("ten_ones", seg_out, 7'h7E);
        to_slot(1'b1);
        chk("ten_tens", seg_out, 7'h30);

        for (int i = 0; i < 5; i++) pulse(1'b0, 2, 2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        to_slot(1'b0);
        chk("held_level_ones", seg_out, 7'h7E);
        pulse(1'b1, 1, 1);
        to_slot(1'b0);
        chk("after_release_ones", seg_out, 7'h30);

        for (int i = 0; i < 88; i++) pulse(1'b1, 1, 1);
        to_slot(1'b0);
        chk("ninety_nine_ones", seg_out, 7'h7B);
        to_slot(1'b1);
        chk("ninety_nine_tens", seg_out, 7'h7B);
        pulse(1'b1, 1, 1);
        to_slot(1'b0);
        chk("wrap_ones", seg_out, 7'h7E);
        to_slot(1'b1);
        chk("wrap_tens", seg_out, TENS_ZERO);

        for (int i = 0; i < 37; i++) pulse(1'b1, 1, 1);
        to_slot(1'b1);
        chk("thirty_seven_tens", seg_out, 7'h79);
        step(1'b1, 1'b1, 1'b1);
        chk("midcount_reset_seg", seg_out, 7'h7E);
        chk("midcount_reset_ds", {6'b0, digit_select}, 7'h00);
        for (int i = 0; i < 2 * DIV; i++) step(1'b1, 1'b0, 1'b0);

        step(1'b0, 1'b0, 1'b1);
        for (int d = 0; d < 10; d++) begin
            to_slot(1'b0);
            chk($sformatf("digit_%0d", d), seg_out, enc[d]);
            pulse(1'b1, 1, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
